ps2_mouse_ctrl: RTL and testbench

- Host-side sequencer for a PS/2 mouse on PS2_CLK1/PS2_DATA1.
- Sits between the byte-level PS/2 transceiver (handshake below) and user logic in Top.
- Runs the power-up sequence: reset 0xFF, ACK, self-test pass (BAT) 0xAA, ID 0x00, enable 0xF4, ACK.
- Then assembles 3-byte stream packets into buttons/dx/dy with a one-cycle valid strobe. Retries on timeout or NAK.

---
 rtl/ps2_mouse_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_mouse_ctrl
//
// Host-side sequencer for a PS/2 mouse. It sits between a byte-level PS/2
// transceiver and user logic. After reset it runs the mouse power-up
// dialogue:
//   send 0xFF, expect ACK 0xFA, expect self-test pass 0xAA, expect ID 0x00,
//   send 0xF4, expect ACK 0xFA.
// It then enters stream mode and assembles 3-byte movement packets. A
// timeout, NAK or receive error during init restarts the dialogue, up to
// MAX_RETRY times. After that the block parks in a sticky fail state.
//
// Ports
//   CLK50MHZ   in   system clock, all logic on the rising edge
//   RST        in   synchronous active-high reset
//   tx_data    out  command byte for the transceiver
//   tx_req     out  one-cycle send request, tx_data valid in the same cycle
//   tx_busy    in   transceiver busy, no request is raised while high
//   tx_done    in   frame acknowledged by the device (not needed here)
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe for rx_data
//   rx_err     in   one-cycle strobe for a parity/framing error
//   buttons    out  {middle, right, left}
//   dx, dy     out  9-bit two's complement movement
//   pkt_valid  out  one-cycle strobe, buttons/dx/dy were just updated
//   ready      out  high while in stream mode
//   fail       out  sticky, retries exhausted
//   state_dbg  out  current state encoding for LEDs
// ---------------------------------------------------------------------------
module ps2_mouse_ctrl #(
  parameter int unsigned ACK_TIMEOUT = 1000000,
  parameter int unsigned BAT_TIMEOUT = 50000000,
  parameter int unsigned PKT_TIMEOUT = 100000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK50MHZ,
  input  logic       RST,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_busy,
  input  logic       tx_done,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [2:0] buttons,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       pkt_valid,
  output logic       ready,
  output logic       fail,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    ST_SEND_RST = 4'd0,
    ST_ACK_RST  = 4'd1,
    ST_WAIT_BAT = 4'd2,
    ST_WAIT_ID  = 4'd3,
    ST_SEND_EN  = 4'd4,
    ST_ACK_EN   = 4'd5,
    ST_PKT0     = 4'd6,
    ST_PKT1     = 4'd7,
    ST_PKT2     = 4'd8,
    ST_RETRY    = 4'd9,
    ST_FAIL     = 4'd10
  } state_e;

  localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);

  state_e      state_q;
  logic [31:0] timer_q;
  logic        half_q;
  logic [7:0]  retry_q;
  logic        cand_q;
  logic [7:0]  b0_q;
  logic [7:0]  b1_q;
  logic [7:0]  tx_data_q;
  logic        tx_req_q;
  logic [2:0]  buttons_q;
  logic [8:0]  dx_q;
  logic [8:0]  dy_q;
  logic        pkt_valid_q;
  logic        ready_q;
  logic        fail_q;

  logic [31:0] timer_lim;
  logic        timed_out;
  logic [8:0]  dx_d;
  logic [8:0]  dy_d;
  logic        tx_done_unused;

  // Completion of a frame is implied by the answer byte, so tx_done carries
  // no information the sequencer needs.
  assign tx_done_unused = tx_done;

  // Each waiting state has its own patience. States that do not wait on the
  // mouse get a zero limit, which also keeps the timer parked at zero there.
  always_comb begin
    timer_lim = '0;
    case (state_q)
      ST_ACK_RST, ST_ACK_EN:   timer_lim = ACK_TIMEOUT;
      ST_WAIT_BAT, ST_WAIT_ID: timer_lim = BAT_TIMEOUT;
      ST_PKT1, ST_PKT2:        timer_lim = PKT_TIMEOUT;
      default:                 timer_lim = '0;
    endcase
  end

  assign timed_out = (timer_q >= timer_lim);

  // Movement decode for the byte completing a packet. The X/Y overflow flags
  // replace the value with the full-scale value of the reported sign, so an
  // overflowed motion never reads as a small number in the wrong direction.
  always_comb begin
    dx_d = {b0_q[4], b1_q};
    dy_d = {b0_q[5], rx_data};
    if (b0_q[6]) begin
      dx_d = b0_q[4] ? 9'h100 : 9'h0FF;
    end
    if (b0_q[7]) begin
      dy_d = b0_q[5] ? 9'h100 : 9'h0FF;
    end
  end

  // Main sequencer. Every transition clears the timer and its half-rate
  // phase so each state starts counting from zero. A received byte is
  // examined before the timeout, so a byte arriving on the timeout cycle is
  // still honoured.
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state_q     <= ST_SEND_RST;
      timer_q     <= '0;
      half_q      <= 1'b0;
      retry_q     <= '0;
      cand_q      <= 1'b0;
      b0_q        <= '0;
      b1_q        <= '0;
      tx_data_q   <= '0;
      tx_req_q    <= 1'b0;
      buttons_q   <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      pkt_valid_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      tx_req_q    <= 1'b0;
      pkt_valid_q <= 1'b0;

      if (rx_valid) begin
        timer_q <= '0;
        half_q  <= 1'b0;
      end else begin
        half_q <= ~half_q;
        if (half_q && (timer_q < timer_lim)) begin
          timer_q <= timer_q + 32'd1;
        end
      end

      case (state_q)
        ST_SEND_RST: begin
          if (!tx_busy) begin
            tx_data_q <= 8'hFF;
            tx_req_q  <= 1'b1;
            state_q   <= ST_ACK_RST;
            timer_q   <= '0;
            half_q    <= 1'b0;
          end
        end

        ST_ACK_RST: begin
          if (rx_valid) begin
            state_q <= (rx_data == 8'hFA) ? ST_WAIT_BAT : ST_RETRY;
          end else if (rx_err || timed_out) begin
            state_q <= ST_RETRY;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        ST_WAIT_BAT: begin
          if (rx_valid) begin
            state_q <= (rx_data == 8'hAA) ? ST_WAIT_ID : ST_RETRY;
          end else if (rx_err || timed_out) begin
            state_q <= ST_RETRY;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        ST_WAIT_ID: begin
          if (rx_valid) begin
            state_q <= (rx_data == 8'h00) ? ST_SEND_EN : ST_RETRY;
          end else if (rx_err || timed_out) begin
            state_q <= ST_RETRY;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        ST_SEND_EN: begin
          if (!tx_busy) begin
            tx_data_q <= 8'hF4;
            tx_req_q  <= 1'b1;
            state_q   <= ST_ACK_EN;
            timer_q   <= '0;
            half_q    <= 1'b0;
          end
        end

        ST_ACK_EN: begin
          if (rx_valid) begin
            if (rx_data == 8'hFA) begin
              state_q <= ST_PKT0;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_RETRY;
            end
          end else if (rx_err || timed_out) begin
            state_q <= ST_RETRY;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        // Only a byte with the sync bit set can start a packet. 0xAA also
        // qualifies, so it is remembered as a possible hot-plug announcement.
        ST_PKT0: begin
          if (rx_valid && rx_data[3]) begin
            b0_q    <= rx_data;
            cand_q  <= (rx_data == 8'hAA);
            state_q <= ST_PKT1;
          end
        end

        ST_PKT1: begin
          if (rx_valid) begin
            if (cand_q && (rx_data == 8'h00)) begin
              ready_q <= 1'b0;
              state_q <= ST_SEND_EN;
            end else begin
              b1_q    <= rx_data;
              state_q <= ST_PKT2;
            end
          end else if (rx_err || timed_out) begin
            state_q <= ST_PKT0;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        ST_PKT2: begin
          if (rx_valid) begin
            buttons_q   <= b0_q[2:0];
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            pkt_valid_q <= 1'b1;
            state_q     <= ST_PKT0;
          end else if (rx_err || timed_out) begin
            state_q <= ST_PKT0;
            timer_q <= '0;
            half_q  <= 1'b0;
          end
        end

        ST_RETRY: begin
          ready_q <= 1'b0;
          timer_q <= '0;
          half_q  <= 1'b0;
          if (retry_q < MAX_RETRY_W) begin
            retry_q <= retry_q + 8'd1;
            state_q <= ST_SEND_RST;
          end else begin
            fail_q  <= 1'b1;
            state_q <= ST_FAIL;
          end
        end

        ST_FAIL: begin
          fail_q <= 1'b1;
        end

        default: begin
          state_q <= ST_SEND_RST;
          timer_q <= '0;
          half_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign buttons   = buttons_q;
  assign dx        = dx_q;
  assign dy        = dy_q;
  assign pkt_valid = pkt_valid_q;
  assign ready     = ready_q;
  assign fail      = fail_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ps2_mouse_ctrl
//
// Plays the part of the transceiver and the mouse. Commands the host is
// expected to send and packets it is expected to report are queued as the
// stimulus is issued; a monitor on the falling clock edge pops and compares
// whenever tx_req or pkt_valid is seen. Expected packets come from an
// arithmetic model of the mouse packet format.
// ---------------------------------------------------------------------------
module tb_ps2_mouse_ctrl;

  localparam int ACK_T = 100;
  localparam int BAT_T = 300;
  localparam int PKT_T = 200;
  localparam int MAXR  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [2:0] buttons;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       pkt_valid;
  logic       ready;
  logic       fail;
  logic [3:0] state_dbg;

  int checkCount = 0;
  int passCount  = 0;
  int txSeen     = 0;

  logic [7:0]  expTx[$];
  logic [20:0] expPkt[$];
  logic [20:0] ePkt;
  logic [20:0] lastPkt;

  ps2_mouse_ctrl #(
    .ACK_TIMEOUT(ACK_T),
    .BAT_TIMEOUT(BAT_T),
    .PKT_TIMEOUT(PKT_T),
    .MAX_RETRY  (MAXR)
  ) dut (
    .CLK50MHZ (clk),
    .RST      (rst),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .buttons  (buttons),
    .dx       (dx),
    .dy       (dy),
    .pkt_valid(pkt_valid),
    .ready    (ready),
    .fail     (fail),
    .state_dbg(state_dbg)
  );

  // Free-running 100 MHz-style clock for simulation.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Mouse packet semantics: 9-bit signed motion, overflow forces full scale
  // in the direction given by the sign bit.
  function automatic logic [20:0] refPacket(input logic [7:0] b0,
                                            input logic [7:0] b1,
                                            input logic [7:0] b2);
    int x;
    int y;
    logic [8:0] xs;
    logic [8:0] ys;
    x = int'(b1) - (b0[4] ? 256 : 0);
    y = int'(b2) - (b0[5] ? 256 : 0);
    if (b0[6]) x = b0[4] ? -256 : 255;
    if (b0[7]) y = b0[5] ? -256 : 255;
    xs = x[8:0];
    ys = y[8:0];
    return {b0[2:0], xs, ys};
  endfunction

  // Monitor: every command and every packet the DUT presents must have been
  // predicted, in order.
  always @(negedge clk) begin
    if (tx_req) begin
      txSeen++;
      checkOutput("txPredicted", 32'(expTx.size() != 0), 32'd1);
      if (expTx.size() != 0) begin
        checkOutput("txData", 32'(tx_data), 32'(expTx.pop_front()));
      end
    end
    if (pkt_valid) begin
      checkOutput("pktPredicted", 32'(expPkt.size() != 0), 32'd1);
      if (expPkt.size() != 0) begin
        ePkt = expPkt.pop_front();
        lastPkt = ePkt;
        checkOutput("pktButtons", 32'(buttons), 32'(ePkt[20:18]));
        checkOutput("pktDx", 32'(dx), 32'(ePkt[17:9]));
        checkOutput("pktDy", 32'(dy), 32'(ePkt[8:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    repeat ($urandom_range(0, 3)) @(posedge clk);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic pulseErr();
    @(posedge clk);
    #1;
    rx_err = 1'b1;
    @(posedge clk);
    #1;
    rx_err = 1'b0;
  endtask

  task automatic waitTx(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (tx_req) seen = 1'b1;
    end
    checkOutput(name, 32'(seen), 32'd1);
  endtask

  task automatic sendPacket(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2);
    applyStimulus(b0);
    applyStimulus(b1);
    expPkt.push_back(refPacket(b0, b1, b2));
    applyStimulus(b2);
  endtask

  task automatic pulseReset();
    tx_busy = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Full power-up dialogue, optionally with a NAK to the first reset command.
  task automatic doInit(input logic nak);
    tx_busy = 1'b1;
    idle(5);
    expTx.push_back(8'hFF);
    tx_busy = 1'b0;
    waitTx("txRstSent");
    if (nak) begin
      expTx.push_back(8'hFF);
      applyStimulus(8'hFE);
      waitTx("txRstResent");
    end
    applyStimulus(8'hFA);
    applyStimulus(8'hAA);
    expTx.push_back(8'hF4);
    applyStimulus(8'h00);
    waitTx("txEnSent");
    applyStimulus(8'hFA);
    idle(2);
    checkOutput("initReady", 32'(ready), 32'd1);
    checkOutput("initState", 32'(state_dbg), 32'd6);
    checkOutput("initFail", 32'(fail), 32'd0);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, "TxData"}, 32'(tx_data), 32'd0);
    checkOutput({tag, "TxReq"}, 32'(tx_req), 32'd0);
    checkOutput({tag, "Buttons"}, 32'(buttons), 32'd0);
    checkOutput({tag, "Dx"}, 32'(dx), 32'd0);
    checkOutput({tag, "Dy"}, 32'(dy), 32'd0);
    checkOutput({tag, "PktValid"}, 32'(pkt_valid), 32'd0);
    checkOutput({tag, "Ready"}, 32'(ready), 32'd0);
    checkOutput({tag, "Fail"}, 32'(fail), 32'd0);
    checkOutput({tag, "State"}, 32'(state_dbg), 32'd0);
  endtask

  // Hard stop if something hangs despite the bounded waits.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int txBase;
    logic [7:0] b0;
    logic seenFail;

    rst      = 1'b1;
    tx_busy  = 1'b1;
    tx_done  = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    rx_err   = 1'b0;
    lastPkt  = '0;

    idle(3);
    @(negedge clk);
    checkCleared("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Init with one NAK-driven retry, then the directed packets.
    doInit(1'b1);
    sendPacket(8'h09, 8'h10, 8'hF0);
    sendPacket(8'h39, 8'h05, 8'hFB);
    applyStimulus(8'h02);
    sendPacket(8'h58, 8'h00, 8'h00);
    sendPacket(8'h48, 8'h00, 8'h00);
    sendPacket(8'hAA, 8'h11, 8'h22);

    // Outputs must hold between strobes.
    idle(6);
    checkOutput("holdDx", 32'(dx), 32'(lastPkt[17:9]));
    checkOutput("holdDy", 32'(dy), 32'(lastPkt[8:0]));

    // Partial packet abandoned by a long gap.
    applyStimulus(8'h08);
    applyStimulus(8'h01);
    idle(2 * PKT_T + 10);
    checkOutput("partialBackToPkt0", 32'(state_dbg), 32'd6);
    sendPacket(8'h08, 8'h02, 8'h03);

    // Partial packet abandoned by a receive error.
    applyStimulus(8'h08);
    applyStimulus(8'h05);
    pulseErr();
    sendPacket(8'h1C, 8'h7F, 8'h80);

    // Random traffic: junk bytes without sync, stray errors in PKT0, packets.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) applyStimulus(8'($urandom) & 8'hF7);
      if ($urandom_range(0, 4) == 0) pulseErr();
      b0 = 8'($urandom) | 8'h08;
      if (b0 == 8'hAA) b0 = 8'hAB;
      sendPacket(b0, 8'($urandom), 8'($urandom));
    end

    // Hot-plug announcement in stream mode re-enables the mouse.
    applyStimulus(8'hAA);
    expTx.push_back(8'hF4);
    applyStimulus(8'h00);
    checkOutput("hotplugReady", 32'(ready), 32'd0);
    checkOutput("hotplugState", 32'(state_dbg), 32'd4);
    waitTx("hotplugEnSent");
    applyStimulus(8'hFA);
    idle(2);
    checkOutput("hotplugReadyBack", 32'(ready), 32'd1);
    sendPacket(8'h0A, 8'h33, 8'h44);

    // Reset in the middle of a packet.
    applyStimulus(8'h09);
    pulseReset();
    @(negedge clk);
    checkCleared("midReset");
    applyStimulus(8'h10);
    applyStimulus(8'hF0);
    doInit(1'b0);
    sendPacket(8'h0B, 8'h01, 8'h02);

    // Silent mouse: initial attempt plus MAXR retries, then sticky fail.
    pulseReset();
    idle(2);
    txBase = txSeen;
    for (int i = 0; i <= MAXR; i++) expTx.push_back(8'hFF);
    tx_busy = 1'b0;
    seenFail = 1'b0;
    for (int i = 0; i < 4000 && !seenFail; i++) begin
      @(negedge clk);
      if (fail) seenFail = 1'b1;
    end
    checkOutput("failSet", 32'(seenFail), 32'd1);
    checkOutput("failState", 32'(state_dbg), 32'd10);
    checkOutput("failReady", 32'(ready), 32'd0);
    checkOutput("failRstCount", 32'(txSeen - txBase), 32'(MAXR + 1));
    idle(2 * ACK_T + 50);
    checkOutput("failSticky", 32'(fail), 32'd1);
    checkOutput("failNoMoreTx", 32'(txSeen - txBase), 32'(MAXR + 1));

    // Reset leaves the fail state and the dialogue works again.
    pulseReset();
    @(negedge clk);
    checkOutput("failCleared", 32'(fail), 32'd0);
    checkOutput("failClearedState", 32'(state_dbg), 32'd0);
    doInit(1'b0);
    sendPacket(8'h29, 8'h80, 8'h7F);

    idle(5);
    checkOutput("txQueueDrained", 32'(expTx.size()), 32'd0);
    checkOutput("pktQueueDrained", 32'(expPkt.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
